// File: rtl/aes_block_loader.sv
// Byte-serial loader feeding the AES core: assembles plaintext and key bytes into
// 128-bit words and hands off complete blocks; the key persists across blocks.
module aes_block_loader (
    input  logic         clk,
    input  logic         rst,
    input  logic [7:0]   in_data,
    input  logic         in_is_key,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [127:0] blk_text,
    output logic [127:0] blk_key,
    output logic         blk_valid,
    input  logic         blk_ready,
    output logic         key_loaded,
    output logic [7:0]   blk_count
);

    typedef enum logic [0:0] {ST_LOAD = 1'b0, ST_FULL = 1'b1} state_t;

    state_t       state_r;
    state_t       state_nx_s;
    logic [4:0]   text_cnt_r;
    logic [4:0]   key_cnt_r;
    logic [4:0]   text_cnt_nx_s;
    logic [4:0]   key_cnt_nx_s;
    logic [127:0] text_sr_r;
    logic [127:0] key_sr_r;
    logic         key_loaded_r;
    logic [7:0]   blk_count_r;
    logic         in_ready_s;
    logic         blk_valid_s;
    logic         accept_s;
    logic         consume_s;
    logic         key_wrap_s;
    logic [3:0]   key_idx_s;

    // Byte lane idx occupies bits [127-8*idx -: 8], so the first byte lands in the MSBs
    function automatic logic [127:0] put_byte(input logic [127:0] word,
                                              input logic [3:0]   idx,
                                              input logic [7:0]   data);
        logic [127:0] res;
        res = word;
        for (int i = 0; i < 16; i++) begin
            res[127 - 8*i -: 8] = (idx == i[3:0]) ? data : word[127 - 8*i -: 8];
        end
        return res;
    endfunction

    assign accept_s   = in_valid & in_ready_s;
    assign consume_s  = blk_valid_s & blk_ready;
    assign key_wrap_s = (key_cnt_r == 5'd16);
    assign key_idx_s  = key_wrap_s ? 4'd0 : key_cnt_r[3:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next fill counts; a key byte arriving on a complete key starts a fresh key
    always_comb begin
        text_cnt_nx_s = text_cnt_r;
        key_cnt_nx_s  = key_cnt_r;
        if (consume_s) begin
            text_cnt_nx_s = 5'd0;
        end else if (accept_s && !in_is_key) begin
            text_cnt_nx_s = text_cnt_r + 5'd1;
        end else if (accept_s && in_is_key) begin
            key_cnt_nx_s = key_wrap_s ? 5'd1 : key_cnt_r + 5'd1;
        end else begin
            text_cnt_nx_s = text_cnt_r;
        end
    end

    // Next-state: block is full once both words are complete, whichever byte finished it
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_LOAD: begin
                if ((text_cnt_nx_s == 5'd16) && (key_cnt_nx_s == 5'd16)) begin
                    state_nx_s = ST_FULL;
                end else begin
                    state_nx_s = ST_LOAD;
                end
            end
            ST_FULL: begin
                if (consume_s) begin
                    state_nx_s = ST_LOAD;
                end else begin
                    state_nx_s = ST_FULL;
                end
            end
            default: state_nx_s = ST_LOAD;
        endcase
    end

    // Handshake outputs; byte port is closed while a block is on offer
    always_comb begin
        in_ready_s  = 1'b0;
        blk_valid_s = 1'b0;
        case (state_r)
            ST_LOAD: begin
                in_ready_s  = in_is_key | (text_cnt_r < 5'd16);
                blk_valid_s = 1'b0;
            end
            ST_FULL: begin
                in_ready_s  = 1'b0;
                blk_valid_s = 1'b1;
            end
            default: begin
                in_ready_s  = 1'b0;
                blk_valid_s = 1'b0;
            end
        endcase
    end

    // Datapath: counters, shift registers, key status and consumed-block count
    always_ff @(posedge clk) begin
        if (rst) begin
            text_cnt_r   <= 5'd0;
            key_cnt_r    <= 5'd0;
            text_sr_r    <= 128'd0;
            key_sr_r     <= 128'd0;
            key_loaded_r <= 1'b0;
            blk_count_r  <= 8'd0;
        end else begin
            text_cnt_r   <= text_cnt_nx_s;
            key_cnt_r    <= key_cnt_nx_s;
            key_loaded_r <= (key_cnt_nx_s == 5'd16);
            if (accept_s && !in_is_key) begin
                text_sr_r <= put_byte(text_sr_r, text_cnt_r[3:0], in_data);
            end
            if (accept_s && in_is_key) begin
                key_sr_r <= put_byte(key_sr_r, key_idx_s, in_data);
            end
            if (consume_s) begin
                blk_count_r <= blk_count_r + 8'd1;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign blk_valid  = blk_valid_s;
    assign blk_text   = text_sr_r;
    assign blk_key    = key_sr_r;
    assign key_loaded = key_loaded_r;
    assign blk_count  = blk_count_r;

endmodule

// File: tb/tb_aes_block_loader.sv
// Self-checking bench for aes_block_loader: directed scenarios plus random traffic
// compared against a byte-array model of the loader.
module tb_aes_block_loader;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [7:0]   in_data = 8'd0;
    logic         in_is_key = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] blk_text;
    logic [127:0] blk_key;
    logic         blk_valid;
    logic         blk_ready = 1'b0;
    logic         key_loaded;
    logic [7:0]   blk_count;

    int checks = 0;
    int errors = 0;

    // Reference model: bytes kept in arrays, in load order
    logic [7:0] m_text [16];
    logic [7:0] m_key  [16];
    int         m_tc, m_kc, m_cnt;
    bit         m_full;

    localparam logic [127:0] C1_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_TEXT = 128'h00112233445566778899aabbccddeeff;

    aes_block_loader dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_is_key(in_is_key),
        .in_valid(in_valid), .in_ready(in_ready), .blk_text(blk_text),
        .blk_key(blk_key), .blk_valid(blk_valid), .blk_ready(blk_ready),
        .key_loaded(key_loaded), .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    function automatic logic m_ready(input logic k);
        return !m_full && (k || (m_tc < 16));
    endfunction

    function automatic logic [127:0] m_word(input bit is_key);
        logic [127:0] w;
        w = 128'd0;
        for (int i = 0; i < 16; i++) w = {w[119:0], (is_key ? m_key[i] : m_text[i])};
        return w;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 16; i++) begin
            m_text[i] = 8'd0;
            m_key[i]  = 8'd0;
        end
        m_tc = 0; m_kc = 0; m_cnt = 0; m_full = 1'b0;
    endtask

    task automatic m_step(input logic v, input logic k, input logic [7:0] d, input logic br);
        if (m_full) begin
            if (br) begin
                m_full = 1'b0;
                m_tc   = 0;
                m_cnt  = (m_cnt + 1) % 256;
            end
        end else if (v && m_ready(k)) begin
            if (k) begin
                if (m_kc == 16) m_kc = 0;
                m_key[m_kc] = d;
                m_kc++;
            end else begin
                m_text[m_tc] = d;
                m_tc++;
            end
            if (m_tc == 16 && m_kc == 16) m_full = 1'b1;
        end
    endtask

    // One clock of stimulus, entered and left at the falling edge
    task automatic drive_cycle(input logic v, input logic k, input logic [7:0] d,
                               input logic br, output logic obs, output logic exp);
        in_valid = v; in_is_key = k; in_data = d; blk_ready = br;
        #1;
        obs = in_ready;
        exp = m_ready(k);
        @(posedge clk);
        m_step(v, k, d, br);
        @(negedge clk);
        in_valid = 1'b0; blk_ready = 1'b0; in_is_key = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        m_reset();
        @(negedge clk);
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rst_blk_valid got %b exp 0", blk_valid); end
        checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL rst_key_loaded got %b exp 0", key_loaded); end
        checks++; if (blk_count !== 8'd0) begin errors++; $display("FAIL rst_blk_count got %0d exp 0", blk_count); end
        checks++; if ({blk_text, blk_key} !== 256'd0) begin errors++; $display("FAIL rst_words got %h %h exp 0", blk_text, blk_key); end
    endtask

    task automatic test_fips_c1();
        logic o, e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b1, 8'(i), 1'b0, o, e);
            checks++; if (o !== 1'b1) begin errors++; $display("FAIL c1_key_ready byte %0d got %b exp 1", i, o); end
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL c1_early_valid got %b exp 0", blk_valid); end
            end
            drive_cycle(1'b1, 1'b0, 8'(i * 17), 1'b0, o, e);
        end
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL c1_valid got %b exp 1", blk_valid); end
        checks++; if (blk_key !== C1_KEY) begin errors++; $display("FAIL c1_key got %h exp %h", blk_key, C1_KEY); end
        checks++; if (blk_text !== C1_TEXT) begin errors++; $display("FAIL c1_text got %h exp %h", blk_text, C1_TEXT); end
        checks++; if (key_loaded !== 1'b1) begin errors++; $display("FAIL c1_key_loaded got %b exp 1", key_loaded); end
    endtask

    task automatic test_interleaved();
        logic o, e;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive_cycle(1'b1, 1'b0, 8'(i * 17), 1'b0, o, e);
            drive_cycle(1'b1, 1'b1, 8'(i), 1'b0, o, e);
        end
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_is_key = 1'b0; in_data = 8'h5a;
            #1;
            checks++; if (blk_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++; $display("FAIL il_hold cyc %0d valid %b ready %b exp 1 0", c, blk_valid, in_ready); end
            checks++; if (blk_text !== C1_TEXT || blk_key !== C1_KEY) begin
                errors++; $display("FAIL il_stable cyc %0d got %h %h exp %h %h", c, blk_text, blk_key, C1_TEXT, C1_KEY); end
            @(posedge clk);
            m_step(1'b1, 1'b0, 8'h5a, 1'b0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        drive_cycle(1'b0, 1'b0, 8'd0, 1'b1, o, e);
        #1;
        checks++; if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL il_handoff valid %b ready %b exp 0 1", blk_valid, in_ready); end
        checks++; if (blk_count !== 8'd1) begin errors++; $display("FAIL il_count got %0d exp 1", blk_count); end
    endtask

    task automatic test_text_full();
        logic o, e;
        logic [7:0] d;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            drive_cycle(1'b1, 1'b0, d, 1'b0, o, e);
        end
        for (int c = 0; c < 3; c++) begin
            drive_cycle(1'b1, 1'b0, 8'hee, 1'b0, o, e);
            checks++; if (o !== 1'b0) begin errors++; $display("FAIL tf_17th_ready cyc %0d got %b exp 0", c, o); end
        end
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            drive_cycle(1'b1, 1'b1, d, 1'b0, o, e);
            checks++; if (o !== 1'b1) begin errors++; $display("FAIL tf_key_ready byte %0d got %b exp 1", i, o); end
        end
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL tf_valid got %b exp 1", blk_valid); end
        checks++; if (blk_text !== m_word(1'b0)) begin errors++; $display("FAIL tf_text got %h exp %h", blk_text, m_word(1'b0)); end
        checks++; if (blk_key !== m_word(1'b1)) begin errors++; $display("FAIL tf_key got %h exp %h", blk_key, m_word(1'b1)); end
    endtask

    // Continues from a FULL block left by the previous scenario
    task automatic test_key_reuse();
        logic o, e;
        logic [127:0] old_key;
        old_key = m_word(1'b1);
        drive_cycle(1'b0, 1'b0, 8'd0, 1'b1, o, e);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) begin
                checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL kr_early_valid got %b exp 0", blk_valid); end
            end
            drive_cycle(1'b1, 1'b0, 8'(255 - i * 17), 1'b0, o, e);
        end
        checks++; if (blk_valid !== 1'b1) begin errors++; $display("FAIL kr_valid got %b exp 1", blk_valid); end
        checks++; if (blk_key !== old_key) begin errors++; $display("FAIL kr_key got %h exp %h", blk_key, old_key); end
        checks++; if (blk_text !== 128'hffeeddccbbaa99887766554433221100) begin
            errors++; $display("FAIL kr_text got %h exp ffeeddccbbaa99887766554433221100", blk_text); end
        checks++; if (blk_count !== 8'd1) begin errors++; $display("FAIL kr_count1 got %0d exp 1", blk_count); end
        drive_cycle(1'b0, 1'b0, 8'd0, 1'b1, o, e);
        checks++; if (blk_count !== 8'd2) begin errors++; $display("FAIL kr_count2 got %0d exp 2", blk_count); end
    endtask

    task automatic test_key_restart();
        logic o, e;
        drive_cycle(1'b1, 1'b1, 8'haa, 1'b0, o, e);
        checks++; if (key_loaded !== 1'b0) begin errors++; $display("FAIL kx_key_loaded got %b exp 0", key_loaded); end
        checks++; if (blk_key[127:120] !== 8'haa) begin errors++; $display("FAIL kx_first got %h exp aa", blk_key[127:120]); end
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0, o, e);
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL kx_text_only_valid got %b exp 0", blk_valid); end
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin
                checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL kx_early_valid got %b exp 0", blk_valid); end
            end
            drive_cycle(1'b1, 1'b1, 8'($urandom), 1'b0, o, e);
        end
        checks++; if (blk_valid !== 1'b1 || key_loaded !== 1'b1) begin
            errors++; $display("FAIL kx_done valid %b key_loaded %b exp 1 1", blk_valid, key_loaded); end
        checks++; if (blk_key !== m_word(1'b1) || blk_text !== m_word(1'b0)) begin
            errors++; $display("FAIL kx_words got %h %h exp %h %h", blk_text, blk_key, m_word(1'b0), m_word(1'b1)); end
    endtask

    // Entered in FULL from the previous scenario
    task automatic test_reset_full();
        do_reset();
        checks++; if (blk_valid !== 1'b0 || key_loaded !== 1'b0) begin
            errors++; $display("FAIL rf_flags valid %b key_loaded %b exp 0 0", blk_valid, key_loaded); end
        checks++; if (blk_count !== 8'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rf_state count %0d ready %b exp 0 1", blk_count, in_ready); end
    endtask

    task automatic test_random();
        logic o, e, v, k, br;
        logic [7:0] d;
        do_reset();
        for (int c = 0; c < 800; c++) begin
            v  = ($urandom_range(0, 3) != 0);
            k  = $urandom_range(0, 1) == 1;
            br = ($urandom_range(0, 2) == 0);
            d  = 8'($urandom);
            drive_cycle(v, k, d, br, o, e);
            checks++; if (o !== e) begin errors++; $display("FAIL rnd_ready cyc %0d got %b exp %b", c, o, e); end
            checks++; if (blk_valid !== m_full || key_loaded !== (m_kc == 16) || blk_count !== 8'(m_cnt)) begin
                errors++; $display("FAIL rnd_status cyc %0d got %b %b %0d exp %b %b %0d",
                                   c, blk_valid, key_loaded, blk_count, m_full, (m_kc == 16), m_cnt); end
            if (m_full) begin
                checks++; if (blk_text !== m_word(1'b0) || blk_key !== m_word(1'b1)) begin
                    errors++; $display("FAIL rnd_words cyc %0d got %h %h exp %h %h",
                                       c, blk_text, blk_key, m_word(1'b0), m_word(1'b1)); end
            end
        end
    endtask

    task automatic test_wrap();
        logic o, e;
        do_reset();
        for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b1, 8'($urandom), 1'b0, o, e);
        for (int b = 0; b < 256; b++) begin
            for (int i = 0; i < 16; i++) drive_cycle(1'b1, 1'b0, 8'($urandom), 1'b0, o, e);
            if (b == 255) begin
                checks++; if (blk_count !== 8'd255) begin errors++; $display("FAIL wrap_255 got %0d exp 255", blk_count); end
            end
            drive_cycle(1'b0, 1'b0, 8'd0, 1'b1, o, e);
        end
        checks++; if (blk_count !== 8'd0 || m_cnt != 0) begin errors++; $display("FAIL wrap_zero got %0d exp 0", blk_count); end
    endtask

    initial begin
        test_reset();
        test_fips_c1();
        test_interleaved();
        test_text_full();
        test_key_reuse();
        test_key_restart();
        test_reset_full();
        test_random();
        test_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_block_loader.md
# aes_block_loader

Byte-serial input stage directly upstream of the AES cipher FSM. Accepts plaintext and key bytes one per cycle over a valid/ready byte port. Assembles them into 128-bit text and key words in FIPS-197 byte order. Presents a complete block to the cipher core over a valid/ready block port. The key is retained across blocks, so only plaintext must be reloaded per encryption.

## Interface
- No parameters; widths fixed at 8-bit bytes and 128-bit blocks.
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  8  byte to load.
- in_is_key  input  1  1 = key byte, 0 = plaintext byte; qualified by in_valid.
- in_valid  input  1  byte present.
- in_ready  output  1  byte accepted this cycle when in_valid & in_ready.
- blk_text  output  128  assembled plaintext; first byte loaded in [127:120].
- blk_key  output  128  assembled key; first byte loaded in [127:120].
- blk_valid  output  1  block complete and held stable.
- blk_ready  input  1  core consumes block when blk_valid & blk_ready.
- key_loaded  output  1  16 key bytes currently held.
- blk_count  output  8  number of blocks consumed, wraps 255 -> 0.

## Operation
- Registers:
  - text_cnt, key_cnt: 0..16 each.
  - text_sr, key_sr: 128-bit each.
  - key_loaded.
  - state in {LOAD, FULL}.
  - blk_count.
- Byte placement: byte accepted with count k is written to bits [127-8k -: 8]; count then increments.
- LOAD state:
  - Key handshake:
    - If key_cnt < 16, write the byte at key_cnt and increment.
    - If key_cnt = 16 (key already complete), restart: write the byte at index 0, set key_cnt = 1, clear key_loaded.
    - Remaining old key bytes keep stale values until overwritten.
  - Text handshake: write the byte at text_cnt and increment.
  - in_ready (combinational from state, counts and in_is_key):
    - in_ready = (state == LOAD) & (in_is_key | text_cnt < 16).
    - Key bytes are always accepted in LOAD.
    - Text bytes are refused once the text is full.
  - key_loaded is set at the edge where key_cnt becomes 16.
  - Go to FULL at the same edge where, after the update, text_cnt == 16 and key_cnt == 16.
  - This applies whichever byte type completed the block.
- FULL state:
  - in_ready = 0.
  - blk_valid = 1.
  - blk_text and blk_key are held constant.
  - On blk_ready:
    - text_cnt <= 0.
    - blk_count <= blk_count + 1 (mod 256).
    - Return to LOAD.
    - key_cnt, key_sr and key_loaded are retained.
- blk_text and blk_key are driven directly from text_sr and key_sr at all times. They are valid only while blk_valid = 1.
- Reset:
  - state = LOAD; both counts = 0; key_loaded = 0; blk_valid = 0; blk_count = 0.
  - text_sr = 0 and key_sr = 0.
  - in_ready = 1 in the first cycle after reset.
- Reset mid-load or in FULL discards all partial and complete data, including the key.

## Timing
- Throughput: one byte per cycle with no bubbles.
- Latency: blk_valid rises in the cycle immediately after the edge that accepted the completing byte.
- Block handoff and re-accept:
  - blk_valid falls in the cycle after the blk_ready handshake.
  - in_ready for text is 1 in that same cycle.
  - A full block therefore costs at least 17 cycles when the key is already loaded.
- blk_ready while blk_valid = 0 is ignored.
- No simultaneous byte and block handshakes: in_ready = 0 in FULL.
- in_valid with in_ready = 0: the byte is not consumed, and the source holds it.

## Test plan
- FIPS-197 C.1 load:
  - Stimulus: reset, then key bytes 00,01,...,0f, then text bytes 00,11,...,ff, back-to-back.
  - Required: blk_valid high on the cycle after the 32nd handshake.
  - Required: blk_key = 000102030405060708090a0b0c0d0e0f and blk_text = 00112233445566778899aabbccddeeff.
  - Required: key_loaded = 1.
- Interleaved, text first:
  - Stimulus: alternating text and key bytes, text first, with blk_ready held low for 10 cycles.
  - Required: same blk_key and blk_text values as the C.1 load.
  - Required: blk_valid held, in_ready = 0 and outputs stable for all 10 cycles.
- Text full, key incomplete:
  - Stimulus: 16 text bytes, then a 17th text byte with in_valid held.
  - Required: in_ready = 0 for the 17th byte.
  - Stimulus: then 16 key bytes.
  - Required: in_ready = 1 for all key bytes; FULL entered after the 16th key byte; the text is not corrupted.
- Key reuse:
  - Stimulus: after consuming block 1, load a second text only (ff,ee,...,00).
  - Required: blk_valid after 16 bytes; blk_key unchanged; blk_count = 1, then 2 after the second consume.
- Key restart:
  - Stimulus: with the key loaded, send one key byte aa.
  - Required: key_loaded = 0 and blk_key[127:120] = aa.
  - Required: a full text does not raise blk_valid until 15 further key bytes arrive.
- Reset and wrap:
  - Stimulus: assert rst in FULL.
  - Required: next cycle blk_valid = 0, key_loaded = 0, blk_count = 0, in_ready = 1.
  - Stimulus: 256 consumed blocks.
  - Required: blk_count wraps to 0.
